// File: rtl/ft245_sync_phy_if.sv
// ft245_sync_phy_if
//   Byte-level handshake between the USB controller and the FT245
//   synchronous-FIFO PHY.
//   Signals:
//     read        controller -> PHY  single-cycle request to fetch one byte
//     rd_ready    PHY -> controller  host has data and no read is pending
//     data_valid  PHY -> controller  one-cycle strobe qualifying read_data
//     read_data   PHY -> controller  byte received from the host
//     write       controller -> PHY  push write_data into the TX buffer
//     write_data  controller -> PHY  byte to send
//     wr_ready    PHY -> controller  TX buffer can absorb 3 more bytes
//     tx_overflow PHY -> controller  sticky: a write hit a full buffer
//   Modports: master = controller side, slave = PHY side.
interface ft245_sync_phy_if;
  logic       read;
  logic       rd_ready;
  logic       data_valid;
  logic [7:0] read_data;
  logic       write;
  logic [7:0] write_data;
  logic       wr_ready;
  logic       tx_overflow;

  modport master (
    output read, write, write_data,
    input  rd_ready, data_valid, read_data, wr_ready, tx_overflow
  );

  modport slave (
    input  read, write, write_data,
    output rd_ready, data_valid, read_data, wr_ready, tx_overflow
  );
endinterface

// File: rtl/ft245_sync_phy.sv
// ft245_sync_phy
//   Physical-layer adapter between the byte-level USB controller and an
//   FT232H in 245 synchronous FIFO mode. Generates RD#, WR#, OE#, steers
//   the bidirectional data bus and buffers outgoing bytes in a small TX
//   FIFO so bytes issued after TXE# rises are not lost. Single clock
//   domain: FT232H CLKOUT (60 MHz).
//   Ports:
//     clk, rst     CLKOUT and asynchronous active-high reset
//     ctl          controller handshake (ft245_sync_phy_if.slave)
//     ft_rxf_n     RXF#, low = RX data available
//     ft_txe_n     TXE#, low = TX space available
//     ft_data_in   data bus input path
//     ft_data_out  data bus output path (TX FIFO head)
//     ft_data_oe   high = FPGA drives the data bus
//     ft_rd_n      RD#
//     ft_wr_n      WR#
//     ft_oe_n      OE#
module ft245_sync_phy #(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned TX_AW    = $clog2(TX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  ft245_sync_phy_if.slave  ctl,
  input  logic             ft_rxf_n,
  input  logic             ft_txe_n,
  input  logic [7:0]       ft_data_in,
  output logic [7:0]       ft_data_out,
  output logic             ft_data_oe,
  output logic             ft_rd_n,
  output logic             ft_wr_n,
  output logic             ft_oe_n
);

  localparam int unsigned     CW      = TX_AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(TX_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    TX,
    RD_TURN,
    RD_OE,
    RD_DATA,
    RD_END
  } state_t;

  state_t           state_q, state_d;

  logic [7:0]       mem_q [TX_DEPTH];
  logic [TX_AW-1:0] wptr_q, wptr_d;
  logic [TX_AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             rd_pending_q, rd_pending_d;
  logic             data_valid_q, data_valid_d;
  logic [7:0]       read_data_q, read_data_d;
  logic             rd_ready_q, rd_ready_d;
  logic             wr_ready_q, wr_ready_d;
  logic             tx_overflow_q, tx_overflow_d;

  logic             full;
  logic             tx_empty;
  logic             push;
  logic             pop;
  logic             rd_go;
  logic             capture;

  // ---------------------------------------------------------------------
  // TX buffer control
  // ---------------------------------------------------------------------
  assign full     = (cnt_q == DEPTH_C);
  assign tx_empty = (cnt_q == '0);
  assign push     = ctl.write & ~full;

  // WR# depends only on registered state and count; a byte leaves the
  // buffer on any edge where WR# and TXE# are both low.
  assign ft_wr_n  = ~((state_q == TX) & ~tx_empty);
  assign pop      = ~ft_wr_n & ~ft_txe_n;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + TX_AW'(1);
    if (pop)  rptr_d = rptr_q + TX_AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= ctl.write_data;
  end

  // ---------------------------------------------------------------------
  // Read request tracking and status flags
  // ---------------------------------------------------------------------
  assign rd_go   = rd_pending_q & ~ft_rxf_n;
  assign capture = (state_q == RD_DATA) & ~ft_rxf_n;

  always_comb begin
    // A new read is only accepted when none is outstanding; the capture
    // can only happen while one is outstanding, so the two never collide.
    rd_pending_d  = (rd_pending_q & ~capture) | (ctl.read & ~rd_pending_q);
    data_valid_d  = capture;
    read_data_d   = capture ? ft_data_in : read_data_q;
    rd_ready_d    = ~ft_rxf_n & ~rd_pending_q & ~ctl.read;
    wr_ready_d    = ~ft_txe_n & ((DEPTH_C - cnt_d) >= CW'(3));
    tx_overflow_d = tx_overflow_q | (ctl.write & full);
  end

  // ---------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_go)          state_d = RD_TURN;
        else if (!tx_empty) state_d = TX;
      end
      TX: begin
        if (rd_go)
          state_d = RD_TURN;
        else if ((tx_empty & ~push) | ((cnt_q == CW'(1)) & pop & ~push))
          state_d = IDLE;
      end
      RD_TURN: state_d = RD_OE;
      RD_OE:   state_d = RD_DATA;
      RD_DATA: state_d = RD_END;
      RD_END:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      rd_pending_q  <= 1'b0;
      data_valid_q  <= 1'b0;
      read_data_q   <= '0;
      rd_ready_q    <= 1'b0;
      wr_ready_q    <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      rd_pending_q  <= rd_pending_d;
      data_valid_q  <= data_valid_d;
      read_data_q   <= read_data_d;
      rd_ready_q    <= rd_ready_d;
      wr_ready_q    <= wr_ready_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: pure decodes of the state register, so the FPGA drive enable
  // (TX only) and OE# low (RD_OE/RD_DATA only) can never overlap.
  // ---------------------------------------------------------------------
  assign ft_data_oe  = (state_q == TX);
  assign ft_oe_n     = ~((state_q == RD_OE) | (state_q == RD_DATA));
  assign ft_rd_n     = ~(state_q == RD_DATA);
  assign ft_data_out = mem_q[rptr_q];

  assign ctl.rd_ready    = rd_ready_q;
  assign ctl.data_valid  = data_valid_q;
  assign ctl.read_data   = read_data_q;
  assign ctl.wr_ready    = wr_ready_q;
  assign ctl.tx_overflow = tx_overflow_q;

endmodule

// File: tb/tb_ft245_sync_phy.sv
// tb_ft245_sync_phy
//   Directed self-checking bench for ft245_sync_phy (TX_DEPTH = 8).
//   A posedge monitor records every byte accepted by the FT232H
//   (WR# and TXE# low); scenario tasks compare it and the strobes against
//   hand-computed expectations.
module tb_ft245_sync_phy;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ft_rxf_n;
  logic       ft_txe_n;
  logic [7:0] ft_data_in;
  logic [7:0] ft_data_out;
  logic       ft_data_oe;
  logic       ft_rd_n;
  logic       ft_wr_n;
  logic       ft_oe_n;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int conflicts = 0;
  logic [7:0] tx_q [$];
  int         pop_cyc [$];

  always #8 clk = ~clk;

  ft245_sync_phy_if ctl ();

  ft245_sync_phy #(.TX_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctl        (ctl),
    .ft_rxf_n   (ft_rxf_n),
    .ft_txe_n   (ft_txe_n),
    .ft_data_in (ft_data_in),
    .ft_data_out(ft_data_out),
    .ft_data_oe (ft_data_oe),
    .ft_rd_n    (ft_rd_n),
    .ft_wr_n    (ft_wr_n),
    .ft_oe_n    (ft_oe_n)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && !ft_wr_n && !ft_txe_n) begin
      tx_q.push_back(ft_data_out);
      pop_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (ft_data_oe && !ft_oe_n) conflicts <= conflicts + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({ft_rd_n, ft_wr_n, ft_oe_n, ft_data_oe} !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 1110", {ft_rd_n, ft_wr_n, ft_oe_n, ft_data_oe});
    end
    n_checks++;
    if ({ctl.data_valid, ctl.rd_ready, ctl.wr_ready, ctl.tx_overflow} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {ctl.data_valid, ctl.rd_ready, ctl.wr_ready, ctl.tx_overflow});
    end
    n_checks++;
    if (ctl.read_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_read_data: got %h expected 00", ctl.read_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    // {oe_n, rd_n, data_valid, rd_ready, data_oe} after edges E1..E5
    logic [4:0] exp_v [5];
    exp_v = '{5'b11000, 5'b01000, 5'b00000, 5'b11100, 5'b11010};
    ft_rxf_n   = 1'b0;
    ft_data_in = 8'h11;
    tick();
    tick();
    n_checks++;
    if (ctl.rd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_rd_ready_idle: got %b expected 1", ctl.rd_ready);
    end
    ctl.read = 1'b1;
    tick();
    ctl.read = 1'b0;
    n_checks++;
    if (ctl.rd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL read_rd_ready_drop: got %b expected 0", ctl.rd_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if ({ft_oe_n, ft_rd_n, ctl.data_valid, ctl.rd_ready, ft_data_oe} !== exp_v[k]) begin
        n_fail++;
        $display("FAIL read_seq_E%0d: got %b expected %b", k + 1,
                 {ft_oe_n, ft_rd_n, ctl.data_valid, ctl.rd_ready, ft_data_oe}, exp_v[k]);
      end
      if (k == 3) begin
        n_checks++;
        if (ctl.read_data !== 8'h11) begin
          n_fail++;
          $display("FAIL read_data: got %h expected 11", ctl.read_data);
        end
      end
    end
    ft_rxf_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int notready = 0;
    int bad = 0;
    int gaps = 0;
    logic [7:0] exp_b;
    tx_q.delete();
    pop_cyc.delete();
    ft_txe_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 128; i++) begin
      ctl.write      = 1'b1;
      ctl.write_data = (i == 0) ? 8'hAA : 8'(i);
      tick();
      if (ctl.wr_ready !== 1'b1) notready++;
    end
    ctl.write = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (notready != 0) begin
      n_fail++;
      $display("FAIL stream_wr_ready: %0d low cycles, expected 0", notready);
    end
    n_checks++;
    if (tx_q.size() != 128) begin
      n_fail++;
      $display("FAIL stream_count: got %0d bytes expected 128", tx_q.size());
    end
    for (int i = 0; i < tx_q.size() && i < 128; i++) begin
      exp_b = (i == 0) ? 8'hAA : 8'(i);
      if (tx_q[i] !== exp_b) bad++;
      if (i > 0 && pop_cyc[i] != pop_cyc[i-1] + 1) gaps++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stream_order: %0d wrong bytes, expected 0", bad);
    end
    n_checks++;
    if (gaps != 0) begin
      n_fail++;
      $display("FAIL stream_gaps: %0d gaps, expected 0", gaps);
    end
  endtask

  task automatic test_txe_stall();
    logic [7:0] sent_q [$];
    logic [7:0] held = 8'h00;
    int after_high = 0;
    int bad = 0;
    int wrong = 0;
    tx_q.delete();
    for (int c = 0; c < 60; c++) begin
      if (c == 20) ft_txe_n = 1'b1;
      if (c == 30) ft_txe_n = 1'b0;
      if (ctl.wr_ready && sent_q.size() < 40) begin
        ctl.write      = 1'b1;
        ctl.write_data = 8'h80 + 8'(sent_q.size());
        sent_q.push_back(ctl.write_data);
        if (c >= 20 && c < 30) after_high++;
      end else begin
        ctl.write = 1'b0;
      end
      tick();
      if (c == 22) held = ft_data_out;
      if (c >= 22 && c < 29 && (ft_wr_n !== 1'b0 || ft_data_out !== held)) bad++;
      if (c == 23) begin
        n_checks++;
        if (ctl.wr_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_wr_ready: got %b expected 0", ctl.wr_ready);
        end
      end
    end
    ctl.write = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (after_high > 2) begin
      n_fail++;
      $display("FAIL stall_late_writes: got %0d expected <=2", after_high);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d cycles with WR# high or head changed, expected 0", bad);
    end
    n_checks++;
    if (tx_q.size() != sent_q.size()) begin
      n_fail++;
      $display("FAIL stall_count: got %0d bytes expected %0d", tx_q.size(), sent_q.size());
    end
    for (int i = 0; i < tx_q.size() && i < sent_q.size(); i++)
      if (tx_q[i] !== sent_q[i]) wrong++;
    n_checks++;
    if (wrong != 0) begin
      n_fail++;
      $display("FAIL stall_order: %0d wrong bytes expected 0", wrong);
    end
    n_checks++;
    if (ctl.tx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_overflow: got %b expected 0", ctl.tx_overflow);
    end
  endtask

  task automatic test_read_during_tx();
    int wrong = 0;
    tx_q.delete();
    ft_txe_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ctl.write      = 1'b1;
      ctl.write_data = 8'hC1 + 8'(i);
      tick();
    end
    ctl.write = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ft_data_oe, ft_wr_n, ft_data_out} !== {1'b1, 1'b0, 8'hC1}) begin
      n_fail++;
      $display("FAIL rtx_paused_tx: got oe=%b wr_n=%b out=%h expected 1 0 c1", ft_data_oe, ft_wr_n, ft_data_out);
    end
    ft_rxf_n   = 1'b0;
    ft_data_in = 8'h5A;
    ctl.read   = 1'b1;
    tick();
    ctl.read = 1'b0;
    tick();
    n_checks++;
    if ({ft_data_oe, ft_oe_n, ft_rd_n, ft_wr_n} !== 4'b0111) begin
      n_fail++;
      $display("FAIL rtx_turnaround: got %b expected 0111", {ft_data_oe, ft_oe_n, ft_rd_n, ft_wr_n});
    end
    tick();
    n_checks++;
    if ({ft_data_oe, ft_oe_n} !== 2'b00) begin
      n_fail++;
      $display("FAIL rtx_rd_oe: got %b expected 00", {ft_data_oe, ft_oe_n});
    end
    tick();
    tick();
    n_checks++;
    if ({ctl.data_valid, ctl.read_data} !== {1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL rtx_capture: got dv=%b data=%h expected 1 5a", ctl.data_valid, ctl.read_data);
    end
    ft_rxf_n = 1'b1;
    tick();
    ft_txe_n = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (tx_q.size() != 4) begin
      n_fail++;
      $display("FAIL rtx_resume_count: got %0d bytes expected 4", tx_q.size());
    end
    for (int i = 0; i < tx_q.size() && i < 4; i++)
      if (tx_q[i] !== 8'hC1 + 8'(i)) wrong++;
    n_checks++;
    if (wrong != 0) begin
      n_fail++;
      $display("FAIL rtx_resume_order: %0d wrong bytes expected 0", wrong);
    end
  endtask

  task automatic test_overflow();
    int wrong = 0;
    tx_q.delete();
    ft_txe_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      ctl.write      = 1'b1;
      ctl.write_data = 8'hD0 + 8'(i);
      tick();
    end
    ctl.write = 1'b0;
    tick();
    n_checks++;
    if ({ctl.tx_overflow, dut.cnt_q} !== {1'b0, 4'd8}) begin
      n_fail++;
      $display("FAIL ovf_full: got ovf=%b cnt=%0d expected 0 8", ctl.tx_overflow, dut.cnt_q);
    end
    ctl.write      = 1'b1;
    ctl.write_data = 8'hEE;
    tick();
    ctl.write = 1'b0;
    tick();
    n_checks++;
    if (ctl.tx_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b expected 1", ctl.tx_overflow);
    end
    repeat (3) tick();
    n_checks++;
    if ({ctl.tx_overflow, dut.cnt_q} !== {1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf=%b cnt=%0d expected 1 8", ctl.tx_overflow, dut.cnt_q);
    end
    ft_txe_n = 1'b0;
    repeat (15) tick();
    n_checks++;
    if (tx_q.size() != DEPTH || ctl.tx_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drain: got %0d bytes ovf=%b expected 8 1", tx_q.size(), ctl.tx_overflow);
    end
    for (int i = 0; i < tx_q.size() && i < DEPTH; i++)
      if (tx_q[i] !== 8'hD0 + 8'(i)) wrong++;
    n_checks++;
    if (wrong != 0) begin
      n_fail++;
      $display("FAIL ovf_order: %0d wrong bytes expected 0", wrong);
    end
  endtask

  task automatic test_reset_mid_tx();
    tx_q.delete();
    ft_txe_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ctl.write      = 1'b1;
      ctl.write_data = 8'hB0 + 8'(i);
      tick();
    end
    ctl.write = 1'b0;
    tick();
    n_checks++;
    if (ft_wr_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_pre: WR# got %b expected 0", ft_wr_n);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({ft_rd_n, ft_wr_n, ft_oe_n, ft_data_oe, ctl.wr_ready, ctl.tx_overflow} !== 6'b111000 ||
        dut.cnt_q !== 4'd0) begin
      n_fail++;
      $display("FAIL rmid_reset: got %b cnt=%0d expected 111000 cnt=0",
               {ft_rd_n, ft_wr_n, ft_oe_n, ft_data_oe, ctl.wr_ready, ctl.tx_overflow}, dut.cnt_q);
    end
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({ctl.wr_ready, ft_wr_n} !== 2'b01) begin
      n_fail++;
      $display("FAIL rmid_txe_high: got wr_ready=%b wr_n=%b expected 0 1", ctl.wr_ready, ft_wr_n);
    end
    ft_txe_n = 1'b0;
    tick();
    n_checks++;
    if (ctl.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_wr_ready: got %b expected 1", ctl.wr_ready);
    end
    repeat (3) tick();
    n_checks++;
    if (tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL rmid_discard: got %0d bytes sent expected 0", tx_q.size());
    end
  endtask

  task automatic test_rxf_retry();
    int dv_seen = 0;
    logic [7:0] got = 8'h00;
    ft_rxf_n   = 1'b0;
    ft_data_in = 8'h33;
    tick();
    ctl.read = 1'b1;
    tick();
    ctl.read = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ft_oe_n, ft_rd_n} !== 2'b01) begin
      n_fail++;
      $display("FAIL retry_rd_oe: got %b expected 01", {ft_oe_n, ft_rd_n});
    end
    ft_rxf_n = 1'b1;
    repeat (8) begin
      tick();
      if (ctl.data_valid === 1'b1) dv_seen++;
    end
    n_checks++;
    if (dv_seen != 0 || dut.rd_pending_q !== 1'b1 || ctl.rd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL retry_abort: got dv=%0d pending=%b rd_ready=%b expected 0 1 0",
               dv_seen, dut.rd_pending_q, ctl.rd_ready);
    end
    ft_data_in = 8'h77;
    ft_rxf_n   = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (ctl.data_valid === 1'b1) begin
        dv_seen++;
        got = ctl.read_data;
      end
    end
    n_checks++;
    if (dv_seen != 1 || got !== 8'h77 || dut.rd_pending_q !== 1'b0) begin
      n_fail++;
      $display("FAIL retry_complete: got dv=%0d data=%h pending=%b expected 1 77 0",
               dv_seen, got, dut.rd_pending_q);
    end
    ft_rxf_n = 1'b1;
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    ft_rxf_n       = 1'b1;
    ft_txe_n       = 1'b1;
    ft_data_in     = 8'h00;
    ctl.read       = 1'b0;
    ctl.write      = 1'b0;
    ctl.write_data = 8'h00;
    test_reset();
    test_read();
    test_stream();
    test_txe_stall();
    test_read_during_tx();
    test_overflow();
    test_reset_mid_tx();
    test_rxf_retry();
    n_checks++;
    if (conflicts != 0) begin
      n_fail++;
      $display("FAIL bus_conflict: got %0d cycles with data_oe and OE# low, expected 0", conflicts);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
